// File: rtl/io_register_arbiter.sv
// Round-robin arbiter giving several requesters sequenced access to a shared io_register bank.
// Reads take two enable cycles because bank data only reaches the bus after the register latch loads.
module io_register_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned N_REGS     = 8,
    parameter int unsigned N_REQ      = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [N_REQ-1:0]            req_in,
    input  logic [N_REQ-1:0]            write_in,
    input  logic [N_REQ*ADDR_WIDTH-1:0] addr_in,
    input  logic [N_REQ*DATA_WIDTH-1:0] data_in,
    output logic [N_REQ-1:0]            ack_out,
    output logic                        err_out,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        busy_out,
    output logic [N_REGS-1:0]           reg_enable_out,
    output logic                        reg_write_out,
    output logic [DATA_WIDTH-1:0]       reg_data_out,
    input  logic [DATA_WIDTH-1:0]       reg_data_in
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_LOAD,
        RD_CAP,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      grant;
    logic [ADDR_WIDTH-1:0] addr_lat;
    logic [DATA_WIDTH-1:0] data_lat;
    logic                  err_lat;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  found;
    logic [PTR_W-1:0]      pick;
    logic [PTR_W-1:0]      cand;
    int unsigned           idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_err;
    logic                  active;

    // Scan requesters starting at the priority pointer, wrapping once around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        idx   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = PTR_W'(idx);
            if (!found && req_in[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        sel_addr = addr_in[pick*ADDR_WIDTH +: ADDR_WIDTH];
        sel_err  = 32'(sel_addr) >= N_REGS;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (found) begin
                    if (sel_err) begin
                        state_nx = DONE;
                    end else if (write_in[pick]) begin
                        state_nx = WRITE;
                    end else begin
                        state_nx = RD_LOAD;
                    end
                end
            end
            WRITE:   state_nx = DONE;
            RD_LOAD: state_nx = RD_CAP;
            RD_CAP:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            ptr      <= '0;
            grant    <= '0;
            addr_lat <= '0;
            data_lat <= '0;
            err_lat  <= 1'b0;
            rd_data  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && found) begin
                grant    <= pick;
                addr_lat <= sel_addr;
                data_lat <= data_in[pick*DATA_WIDTH +: DATA_WIDTH];
                err_lat  <= sel_err;
            end
            if (state == RD_CAP) begin
                rd_data <= reg_data_in;
            end
            if (state == DONE) begin
                ptr <= (32'(grant) == N_REQ - 1) ? '0 : grant + PTR_W'(1);
            end
        end
    end

    // Every output is decoded from registered state only.
    always_comb begin
        active         = (state == WRITE) || (state == RD_LOAD) || (state == RD_CAP);
        ack_out        = '0;
        reg_enable_out = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            ack_out[i] = (state == DONE) && (32'(grant) == i);
        end
        for (int unsigned i = 0; i < N_REGS; i++) begin
            reg_enable_out[i] = active && (32'(addr_lat) == i);
        end
        err_out       = (state == DONE) && err_lat;
        busy_out      = (state != IDLE);
        reg_write_out = (state == WRITE);
        reg_data_out  = (state == WRITE) ? data_lat : '0;
        data_out      = rd_data;
    end

endmodule

// File: doc/io_register_arbiter.md
# io_register_arbiter

Shares a bank of `io_register` instances between several requesters (e.g. host bus and SPI command decoder) using round-robin arbitration. It sequences each register's enable/write pins, including the two-cycle read needed because register read data only appears on the tri-state bus after the register's internal latch loads. It sits between the requester ports and the shared register bank and is the only block that drives the bank's control pins.

## Interface
- `DATA_WIDTH`, 32, register and data bus width
- `ADDR_WIDTH`, 4, register address width
- `N_REGS`, 8, number of registers in the bank; must satisfy N_REGS <= 2**ADDR_WIDTH
- `N_REQ`, 2, number of requesters; minimum 2
- `clk_in`  input  1  single clock; all state changes on its rising edge
- `rst_n_in`  input  1  reset, asynchronous, active-low
- `req_in`  input  N_REQ  per-requester request, level; held until matching ack
- `write_in`  input  N_REQ  per-requester 1 = write, 0 = read
- `addr_in`  input  N_REQ*ADDR_WIDTH  packed addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `data_in`  input  N_REQ*DATA_WIDTH  packed write data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- `ack_out`  output  N_REQ  one-cycle completion pulse to the granted requester
- `err_out`  output  1  valid with ack; 1 = address >= N_REGS, no access made
- `data_out`  output  DATA_WIDTH  read result; valid with ack, held until the next read ack
- `busy_out`  output  1  1 whenever state != IDLE
- `reg_enable_out`  output  N_REGS  one-hot register enable; all-zero when idle
- `reg_write_out`  output  1  shared write strobe to the bank
- `reg_data_out`  output  DATA_WIDTH  shared write data to the bank
- `reg_data_in`  input  DATA_WIDTH  shared tri-state read bus from the bank

## Operation
- States: IDLE, WRITE, RD_LOAD, RD_CAP, DONE.
- IDLE: if any `req_in` is high, grant the first requester at or after priority pointer `ptr` (wrapping modulo N_REQ). Latch its write flag, address and data into internal registers. Next state:
  - DONE with err=1 if addr >= N_REGS
  - WRITE if write flag = 1
  - RD_LOAD otherwise
- WRITE: reg_enable_out[addr]=1, reg_write_out=1, reg_data_out=latched data. The register commits at the end of this cycle. Next state DONE.
- RD_LOAD: reg_enable_out[addr]=1, reg_write_out=0. The register's internal latch loads at the end of this cycle. Next state RD_CAP.
- RD_CAP: same pin values as RD_LOAD. Sample `reg_data_in` into the `data_out` register at the end of this cycle. Next state DONE.
- DONE: ack_out[grant]=1 for exactly one cycle; err_out reflects the latched error; `ptr` <= (grant+1) mod N_REQ. Next state IDLE.
- Requester inputs are sampled only in IDLE. Changes to inputs while the requester is granted are ignored.
- A request dropped before it is granted is lost silently.
- A requester that keeps req high after its ack is re-arbitrated in the following IDLE cycle. Because `ptr` has advanced, any other pending requester wins first.
- Out-of-range access: no reg_enable_out bit is asserted; data_out is unchanged.
- reg_data_out is driven with the latched write data in WRITE and 0 in all other states. reg_write_out is 1 only in WRITE.

## Timing
- Reset values (immediate on rst_n_in low): state IDLE, ptr=0, ack_out=0, err_out=0, data_out=0, busy_out=0, reg_enable_out=0, reg_write_out=0, reg_data_out=0.
- Reset mid-operation: the transaction is aborted and no ack is issued. If reset arrives before the WRITE-cycle edge, the bank write does not occur; the bank itself keeps its contents.
- Latencies, with the request sampled in IDLE at cycle t:
  - write: enable/write in t+1, ack in t+2
  - read: enable in t+1 and t+2, ack with data in t+3
  - error: ack in t+1
- Throughput: one transaction per 3 cycles (write) or 4 cycles (read), including IDLE. At most one reg_enable_out bit is high in any cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from req_in to ack_out.

## Test plan
- Write requester 0, addr 3, data 0xDEADBEEF -> reg_enable_out=0x08 with reg_write_out=1 for one cycle (t+1); ack_out=01 at t+2; err_out=0.
- Read back addr 3 from requester 1 -> reg_enable_out=0x08 for two cycles with reg_write_out=0; ack_out=10 at t+3; data_out=0xDEADBEEF.
- Both requesters request continuously from reset, reads of addr 1 and addr 2 -> grants alternate 0,1,0,1; each ack is one cycle; the two enables never overlap.
- Requester 0 reads addr 9 (N_REGS=8) -> no enable asserted; ack_out=01 at t+1 with err_out=1; data_out keeps its previous value.
- Assert rst_n_in low during RD_LOAD -> all outputs 0 immediately; no ack. After release, ptr=0 and a new write to addr 0 completes normally.
